// File: rtl/pc_pkg.sv
// Shared types and defaults for the PC / fetch-request stage.
// Build option: PC_MISALIGN_TRAP_EN (see pc_fetch_unit).
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2
    } pc_state_t;

    localparam int          PC_W_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam int          INCR_DEF      = 4;
    localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0010;

    function automatic logic [63:0] align_mask(input int incr);
        align_mask = ~(64'(incr) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux: redirect > sequential advance > hold.
// Build option: PC_MISALIGN_TRAP_EN adds the misaligned-target trap.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int             PC_W     = PC_W_DEF,
    parameter int             INCR     = INCR_DEF,
    parameter logic [PC_W-1:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] target,
    input  logic            pc_load,
    input  logic            fire,
`ifdef PC_MISALIGN_TRAP_EN
    output logic            trap,
`endif
    output logic [PC_W-1:0] pc_next
);

    localparam logic [PC_W-1:0] MASK = PC_W'(align_mask(INCR));

    logic [PC_W-1:0] aligned;

    assign aligned = target & MASK;

`ifdef PC_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (target & ~MASK) != '0;
    assign trap       = pc_load & misaligned;
`endif

    always_comb begin
        pc_next = pc;
        if (pc_load) begin
            pc_next = aligned;
`ifdef PC_MISALIGN_TRAP_EN
            if (misaligned) pc_next = TRAP_VEC;
`endif
        end else if (fire) begin
            pc_next = pc + PC_W'(INCR);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch-request stage with a one-cycle redirect bubble.
// Build option: PC_MISALIGN_TRAP_EN enables misalign_trap and TRAP_VEC.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_VEC = RESET_VEC_DEF,
    parameter int              INCR      = INCR_DEF,
    parameter logic [PC_W-1:0] TRAP_VEC  = TRAP_VEC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_load,
    input  logic [PC_W-1:0] target,
    input  logic            stall,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [PC_W-1:0] pc,
`ifdef PC_MISALIGN_TRAP_EN
    output logic            misalign_trap,
`endif
    output logic            flush
);

    pc_state_t       state;
    logic            load;
    logic            fire;
    logic [PC_W-1:0] pc_next;

    // Redirects are ignored until the first post-reset edge has left BOOT.
    assign load        = pc_load & (state != BOOT);
    assign fetch_valid = (state == FETCH) & ~stall;
    assign fire        = fetch_valid & fetch_ready;

`ifdef PC_MISALIGN_TRAP_EN
    logic trap;
`endif

    pc_next_sel #(
        .PC_W     (PC_W),
        .INCR     (INCR),
        .TRAP_VEC (TRAP_VEC)
    ) u_next (
        .pc      (pc),
        .target  (target),
        .pc_load (load),
        .fire    (fire),
`ifdef PC_MISALIGN_TRAP_EN
        .trap    (trap),
`endif
        .pc_next (pc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            pc    <= RESET_VEC;
            flush <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_trap <= 1'b0;
`endif
        end else begin
            pc <= pc_next;
            unique case (state)
                BOOT: begin
                    state <= FETCH;
                    flush <= 1'b0;
                end
                FETCH, REDIRECT: begin
                    state <= load ? REDIRECT : FETCH;
                    flush <= load;
                end
                default: begin
                    state <= BOOT;
                    flush <= 1'b0;
                end
            endcase
`ifdef PC_MISALIGN_TRAP_EN
            misalign_trap <= trap;
`endif
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; expected values are hand-computed.
// Build option: PC_MISALIGN_TRAP_EN switches the misaligned-target checks.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_load;
    logic [31:0] target;
    logic        stall;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] pc;
    logic        flush;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_load       (pc_load),
        .target        (target),
        .stall         (stall),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .pc            (pc),
`ifdef PC_MISALIGN_TRAP_EN
        .misalign_trap (misalign_trap),
`endif
        .flush         (flush)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic [31:0] epc,
                        input logic efv, input logic efl);
        check({tag, "_pc"}, pc, epc);
        check({tag, "_fv"}, 32'(fetch_valid), 32'(efv));
        check({tag, "_fl"}, 32'(flush), 32'(efl));
    endtask

    initial begin
        rst_n       = 1'b0;
        pc_load     = 1'b0;
        target      = '0;
        stall       = 1'b0;
        fetch_ready = 1'b1;
        #1;
        chk3("rst", 32'h0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        // BOOT cycle: pc_load must be ignored
        pc_load = 1'b1;
        target  = 32'h80;
        #1;
        check("boot_fv", 32'(fetch_valid), 32'h0);
        tick();
        chk3("boot_out", 32'h0, 1'b1, 1'b0);
        pc_load = 1'b0;
        tick();
        chk3("seq4", 32'h4, 1'b1, 1'b0);
        tick();
        chk3("seq8", 32'h8, 1'b1, 1'b0);

        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk3("hold8", 32'h8, 1'b1, 1'b0);
        end
        fetch_ready = 1'b1;
        tick();
        chk3("seqC", 32'hC, 1'b1, 1'b0);

        // redirect coincident with fire
        pc_load = 1'b1;
        target  = 32'h100;
        tick();
        pc_load = 1'b0;
        chk3("redir", 32'h100, 1'b0, 1'b1);
        tick();
        chk3("redir_f", 32'h100, 1'b1, 1'b0);
        tick();
        chk3("seq104", 32'h104, 1'b1, 1'b0);

        pc_load = 1'b1;
        target  = 32'h20;
        tick();
        pc_load = 1'b0;
        chk3("r20", 32'h20, 1'b0, 1'b1);
        tick();
        chk3("r20_f", 32'h20, 1'b1, 1'b0);
        stall = 1'b1;
        #1;
        check("stall_fv", 32'(fetch_valid), 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk3("stall", 32'h20, 1'b0, 1'b0);
        end
        pc_load = 1'b1;
        target  = 32'h40;
        tick();
        pc_load = 1'b0;
        stall   = 1'b0;
        chk3("stall_r", 32'h40, 1'b0, 1'b1);
        tick();
        chk3("stall_rf", 32'h40, 1'b1, 1'b0);

        // back-to-back redirects keep REDIRECT and flush
        pc_load = 1'b1;
        target  = 32'h200;
        tick();
        chk3("dbl1", 32'h200, 1'b0, 1'b1);
        target = 32'h303;
        tick();
        pc_load = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        chk3("dbl2", 32'h10, 1'b0, 1'b1);
`else
        chk3("dbl2", 32'h300, 1'b0, 1'b1);
`endif
        tick();
        pc_load = 1'b1;
        target  = 32'hFFFF_FFFC;
`ifdef PC_MISALIGN_TRAP_EN
        chk3("dbl_f", 32'h10, 1'b1, 1'b0);
`else
        chk3("dbl_f", 32'h300, 1'b1, 1'b0);
`endif
        tick();
        pc_load = 1'b0;
        tick();
        chk3("top", 32'hFFFF_FFFC, 1'b1, 1'b0);
        tick();
        chk3("wrap", 32'h0, 1'b1, 1'b0);

        pc_load = 1'b1;
        target  = 32'h102;
        tick();
        pc_load = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        chk3("mis", 32'h10, 1'b0, 1'b1);
        check("mis_trap", 32'(misalign_trap), 32'h1);
`else
        chk3("mis", 32'h100, 1'b0, 1'b1);
`endif
        // async reset in the middle of REDIRECT
        rst_n = 1'b0;
        #1;
        chk3("mid_rst", 32'h0, 1'b0, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
        check("mid_rst_trap", 32'(misalign_trap), 32'h0);
`endif
        tick();
        chk3("rst_hold", 32'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
